// File: rtl/eth_phy_10g_rx_block_sync.sv
// eth_phy_10g_rx_block_sync
// 64b/66b block-lock state machine for the 10G PHY receive path. It hunts for
// sync-header alignment using SERDES bitslip pulses. It declares lock after
// LOCK_COUNT consecutive valid headers. It drops lock when INVALID_MAX invalid
// headers land inside one WINDOW-header window.
// Optional feature macro: ETH_BLOCK_SYNC_RESET_REQ_EN. When defined, the block
// counts slips since the last lock. It pulses serdes_rx_reset_req on every
// SLIP_LIMIT-th slip.
module eth_phy_10g_rx_block_sync #(
    parameter int LOCK_COUNT          = 64,
    parameter int WINDOW              = 64,
    parameter int INVALID_MAX         = 16,
    parameter int BITSLIP_HIGH_CYCLES = 1,
    parameter int BITSLIP_LOW_CYCLES  = 8,
    parameter int SLIP_LIMIT          = 66
) (
    input  logic                           rx_clk,
    input  logic                           rx_rst,
    input  logic [1:0]                     serdes_rx_hdr,
    input  logic                           serdes_rx_hdr_valid,
    output logic                           serdes_rx_bitslip,
    output logic                           serdes_rx_reset_req,
    output logic                           rx_block_lock,
    output logic [$clog2(WINDOW+1)-1:0]    rx_invalid_hdr_count,
    output logic [15:0]                    rx_lock_loss_count
);

    localparam int RUN_W   = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int TMR_MAX = (BITSLIP_HIGH_CYCLES > BITSLIP_LOW_CYCLES) ?
                             BITSLIP_HIGH_CYCLES : BITSLIP_LOW_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] INV_LAST  = WIN_W'(INVALID_MAX - 1);
    localparam logic [TMR_W-1:0] HIGH_LAST = TMR_W'(BITSLIP_HIGH_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOW_LAST  = TMR_W'(BITSLIP_LOW_CYCLES - 1);

    // Reject parameter sets the counters cannot represent
    if (LOCK_COUNT < 1 || WINDOW < 1 || INVALID_MAX < 1 || INVALID_MAX > WINDOW ||
        BITSLIP_HIGH_CYCLES < 1 || BITSLIP_LOW_CYCLES < 0 || SLIP_LIMIT < 1) begin : g_bad_params
        $error("eth_phy_10g_rx_block_sync: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_HIGH = 2'd1,
        SLIP_LOW  = 2'd2,
        LOCKED    = 2'd3
    } state_e;

    state_e           state_q;
    logic [RUN_W-1:0] run_q;
    logic [WIN_W-1:0] win_q;
    logic [WIN_W-1:0] inv_q;
    logic [TMR_W-1:0] tmr_q;
    logic             bitslip_q;
    logic             lock_q;
    logic [15:0]      loss_q;

    logic             hdr_bad;
    logic             lose_lock;

    // Header classification and the loss-of-lock condition. Loss of lock is
    // evaluated ahead of the window wrap so it wins when both land together.
    always_comb begin
        hdr_bad   = ~^serdes_rx_hdr;
        lose_lock = serdes_rx_hdr_valid && (state_q == LOCKED) && hdr_bad && (inv_q == INV_LAST);
    end

    // Lock FSM with its counters and registered outputs
    always_ff @(posedge rx_clk) begin
        // NOTE: reset is tested inside the clocked block, so it is synchronous and overrides every input.
        if (rx_rst) begin
            state_q   <= HUNT;
            run_q     <= '0;
            win_q     <= '0;
            inv_q     <= '0;
            tmr_q     <= '0;
            bitslip_q <= 1'b0;
            lock_q    <= 1'b0;
            loss_q    <= '0;
        end else begin
            // NOTE: non-blocking updates, so every branch reads the pre-edge values.
            case (state_q)
                HUNT: begin
                    if (serdes_rx_hdr_valid) begin
                        if (hdr_bad) begin
                            run_q     <= '0;
                            tmr_q     <= '0;
                            bitslip_q <= 1'b1;
                            state_q   <= SLIP_HIGH;
                        end else if (run_q == RUN_LAST) begin
                            run_q   <= '0;
                            win_q   <= '0;
                            inv_q   <= '0;
                            lock_q  <= 1'b1;
                            state_q <= LOCKED;
                        end else begin
                            run_q <= run_q + 1'b1;
                        end
                    end
                end
                SLIP_HIGH: begin
                    if (tmr_q == HIGH_LAST) begin
                        tmr_q     <= '0;
                        bitslip_q <= 1'b0;
                        state_q   <= (BITSLIP_LOW_CYCLES == 0) ? HUNT : SLIP_LOW;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                SLIP_LOW: begin
                    if (tmr_q == LOW_LAST) begin
                        tmr_q   <= '0;
                        run_q   <= '0;
                        state_q <= HUNT;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (lose_lock) begin
                        win_q     <= '0;
                        inv_q     <= '0;
                        tmr_q     <= '0;
                        lock_q    <= 1'b0;
                        bitslip_q <= 1'b1;
                        state_q   <= SLIP_HIGH;
                        if (loss_q != 16'hFFFF) loss_q <= loss_q + 1'b1;
                    end else if (serdes_rx_hdr_valid) begin
                        if (win_q == WIN_LAST) begin
                            win_q <= '0;
                            inv_q <= '0;
                        end else begin
                            win_q <= win_q + 1'b1;
                            inv_q <= inv_q + WIN_W'(hdr_bad);
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    assign serdes_rx_bitslip    = bitslip_q;
    assign rx_block_lock        = lock_q;
    assign rx_invalid_hdr_count = inv_q;
    assign rx_lock_loss_count   = loss_q;

`ifdef ETH_BLOCK_SYNC_RESET_REQ_EN
    localparam int SLIP_W = $clog2(SLIP_LIMIT + 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_LIMIT - 1);

    logic [SLIP_W-1:0] slip_cnt_q;
    logic              reset_req_q;
    logic              slip_start;
    logic              enter_lock;

    // A slip starts on a hunt-time bad header or on loss of lock
    assign slip_start = (serdes_rx_hdr_valid && (state_q == HUNT) && hdr_bad) || lose_lock;
    assign enter_lock = serdes_rx_hdr_valid && (state_q == HUNT) && !hdr_bad && (run_q == RUN_LAST);

    // Count slips since the last lock; the reset pulse rises with the limiting slip
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            slip_cnt_q  <= '0;
            reset_req_q <= 1'b0;
        end else begin
            reset_req_q <= 1'b0;
            if (enter_lock) begin
                slip_cnt_q <= '0;
            end else if (slip_start) begin
                if (slip_cnt_q == SLIP_LAST) begin
                    slip_cnt_q  <= '0;
                    reset_req_q <= 1'b1;
                end else begin
                    slip_cnt_q <= slip_cnt_q + 1'b1;
                end
            end
        end
    end

    assign serdes_rx_reset_req = reset_req_q;
`else
    assign serdes_rx_reset_req = 1'b0;
`endif

endmodule

// File: doc/eth_phy_10g_rx_block_sync.md
# eth_phy_10g_rx_block_sync

Parametrised 64b/66b block-lock state machine for the 10G PHY receive path, between the SERDES header interface and the descrambler/decoder. It hunts for sync-header alignment with bitslip pulses. It declares lock after a configurable run of valid headers and drops lock when invalid headers within a sliding-free counting window reach a threshold. It generalises the fixed 64/16 lock rule to programmable lock count, window, invalid threshold and gearbox header-valid gating, and adds lock-loss statistics and an optional SERDES reset request.

## Interface
Parameters:
- LOCK_COUNT, 64: consecutive valid headers required to assert lock
- WINDOW, 64: headers per invalid-count window while locked
- INVALID_MAX, 16: invalid headers within one window that cause loss of lock (1..WINDOW)
- BITSLIP_HIGH_CYCLES, 1: cycles serdes_rx_bitslip is held high per slip (>=1)
- BITSLIP_LOW_CYCLES, 8: settle cycles after each slip, headers ignored (>=0)
- SLIP_LIMIT, 66: slips without lock before reset request (used only with macro)

Ports:
- rx_clk  in  1  clock; all logic on rising edge
- rx_rst  in  1  reset, synchronous, active-high
- serdes_rx_hdr  in  2  sync header of current block
- serdes_rx_hdr_valid  in  1  header qualifier; header sampled only when 1
- serdes_rx_bitslip  out  1  slip request to SERDES
- serdes_rx_reset_req  out  1  one-cycle SERDES reset request pulse
- rx_block_lock  out  1  block lock status
- rx_invalid_hdr_count  out  $clog2(WINDOW+1)  invalid headers in current locked window
- rx_lock_loss_count  out  16  lock-loss events since reset, saturating at 16'hFFFF

## Operation
- Valid header: 2'b01 or 2'b10. Invalid: 2'b00 or 2'b11. Only sampled headers (hdr_valid=1) count.
- States: HUNT, SLIP_HIGH, SLIP_LOW, LOCKED.
- HUNT: valid header increments the run counter. On the LOCK_COUNT-th consecutive valid header, go to LOCKED and clear the window counters. An invalid header clears the run counter and goes to SLIP_HIGH.
- SLIP_HIGH: bitslip=1 for BITSLIP_HIGH_CYCLES cycles, then SLIP_LOW. Headers are ignored.
- SLIP_LOW: bitslip=0 for BITSLIP_LOW_CYCLES cycles; headers ignored. Then HUNT with run counter 0. If BITSLIP_LOW_CYCLES=0, go directly to HUNT.
- LOCKED: each sampled header increments the window count; each invalid header also increments the invalid count.
  - If the invalid count reaches INVALID_MAX, leave LOCKED for SLIP_HIGH, increment rx_lock_loss_count (saturating), and clear both counters.
  - Otherwise, when the window count reaches WINDOW, clear both counters and stay LOCKED.
- Invalid headers need not be consecutive.
- Precedence: if the header that completes the window is also the INVALID_MAX-th invalid header, loss of lock wins.
- rx_invalid_hdr_count is 0 outside LOCKED.

## Timing
- All outputs are registered.
- Reset values: bitslip 0, reset_req 0, block_lock 0, invalid count 0, lock_loss_count 0. State is HUNT and all internal counters are 0.
- rx_rst asserted mid-operation, including mid-slip, returns everything to reset values on the next edge. Reset dominates all other inputs.
- Lock: rx_block_lock rises on the edge after the LOCK_COUNT-th valid header is sampled.
- Unlock: rx_block_lock falls, and serdes_rx_bitslip rises, on the edge after the INVALID_MAX-th invalid header is sampled.
- Hunt slip: bitslip rises on the edge after the invalid header is sampled.
- A slip cycle lasts exactly BITSLIP_HIGH_CYCLES+BITSLIP_LOW_CYCLES cycles before the first header can be sampled in HUNT.
- hdr_valid=0 cycles stall the counters; they neither count nor break a run.

## Configuration
- ETH_BLOCK_SYNC_RESET_REQ_EN defined:
  - Count slips since last lock (or reset); the counter clears on entry to LOCKED.
  - When the count reaches SLIP_LIMIT, pulse serdes_rx_reset_req for exactly one cycle, coincident with the SLIP_LIMIT-th bitslip rising edge, and clear the slip count.
- Not defined: serdes_rx_reset_req is constant 0 and no slip counter is instantiated.

## Test plan
- Reset, then 64 headers 2'b10 with hdr_valid=1 -> rx_block_lock=1 on the edge after the 64th; no bitslip seen.
- Locked, window of 64 with 15 invalid 2'b00 on alternating headers -> lock held, count peaks at 15, returns to 0 after header 64. Repeat with 16 invalid -> lock drops on the edge after the 16th; bitslip high 1 cycle, low 8; rx_lock_loss_count=1.
- HUNT with 2'b11 at header 30 -> bitslip pulse; run restarts, so lock needs 64 further valid headers after the 9-cycle slip.
- Alternate hdr_valid 1/0 with all 2'b01 -> lock after the 64th sampled header (~128 cycles); invalid value presented while hdr_valid=0 is ignored.
- LOCK_COUNT=8, WINDOW=16, INVALID_MAX=4 -> lock after 8, unlock on 4th invalid in 16. Separately, 4th invalid on the 16th header -> unlock, not window clear.
- Macro defined, SLIP_LIMIT=4, constant 2'b00 -> one-cycle reset_req with 4th slip, again at 8th; macro undefined -> reset_req stays 0. Also check rx_rst mid-SLIP_LOW -> all outputs 0 on the next edge.
